cv32e40p_tmr_vote_manager: RTL and testbench
============================================

Name: cv32e40p_tmr_vote_manager

Overview:
- Parametrised successor to the per-output TMR voters used around the triplicated decoders.
- Votes a WIDTH-bit triplicated bus and tracks per-replica disagreement over time.
- Isolates a persistently faulty replica, then continues in duplex, then declares failure.
- Provides the fault management that the existing combinational `fault` bit leaves undone. It sits between a triplicated block and its consumer.

Parameters:
- WIDTH, 32, width of each replica bus and of vote_o.
- PERSIST_THR, 3, consecutive disagreeing valid samples (>=1) before a replica is isolated.
- CNT_WIDTH, 4, width of the saturating mismatch event counter.
- OUT_REG, 0, 0 = vote_o/vote_valid_o/fault_o combinational from inputs; 1 = registered (+1 cycle).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- valid_i, input, 1, inputs carry a sample this cycle.
- in1_i, input, WIDTH, replica 1.
- in2_i, input, WIDTH, replica 2.
- in3_i, input, WIDTH, replica 3.
- clear_i, input, 1, software/controller acknowledge: return to NORMAL.
- vote_o, output, WIDTH, voted word.
- vote_valid_o, output, 1, vote_o is trustworthy this sample.
- fault_o, output, 1, a non-isolated replica disagreed on this sample.
- no_majority_o, output, 1, sticky: voting impossible (FAILED).
- state_o, output, 2, 00 NORMAL, 01 DEGRADED, 10 FAILED.
- faulty_rep_o, output, 2, isolated replica index 1..3; 0 = none.
- err_cnt_o, output, CNT_WIDTH, saturating count of valid samples with fault_o=1.

Behaviour:
- Reset (rst_n=0, async):
  - State NORMAL; all outputs 0.
  - Per-replica consecutive counters 0.
  - Held-vote register 0.
- NORMAL:
  - vote = bitwise majority of in1/in2/in3.
  - Replica i disagrees when in_i != vote (whole word).
  - fault_o = valid_i & any disagreement.
  - All three words pairwise different: transition to FAILED on the next edge. That sample has vote_valid_o=0 and fault_o=1.
- Per-replica consecutive counter (width $clog2(PERSIST_THR+1)):
  - On a valid sample: +1 if the replica disagrees, cleared to 0 if it agrees.
  - valid_i=0: counters hold, so gaps do not break a run.
- Reaching PERSIST_THR in NORMAL: next state DEGRADED, faulty_rep_o=i.
  - A single replica is the only one able to disagree while a majority exists.
  - If more than one would qualify, FAILED takes priority.
- DEGRADED:
  - The isolated replica is ignored entirely; the two remaining replicas are compared.
  - Equal: vote = their value, fault_o=0.
  - Different on a valid sample: fault_o=1, vote_valid_o=0, vote_o = held vote, next state FAILED.
- FAILED:
  - vote_o = held vote (last word output with vote_valid_o=1).
  - vote_valid_o=0, fault_o=0, no_majority_o=1.
  - Counters frozen; holds until clear_i.
- Held vote: updated on every valid sample with vote_valid_o=1 in NORMAL/DEGRADED.
- vote_valid_o = valid_i & (state != FAILED) & a voting result exists.
- err_cnt_o:
  - +1 on each valid sample with fault_o=1.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
- clear_i (synchronous, any state):
  - Next state NORMAL; counters, faulty_rep_o, err_cnt_o and no_majority_o cleared. The held vote is kept.
  - Has priority over any same-cycle counter or state update.
  - The sample in that cycle is still voted under the current state, but is not counted.
- Register timing:
  - state_o, faulty_rep_o, err_cnt_o and no_majority_o are always registered, updating the edge after the causing sample.
  - OUT_REG=1 delays vote_o/vote_valid_o/fault_o by exactly one cycle, aligned with the status outputs.

Test Plan:
1. NORMAL, all replicas 0xDEADBEEF, valid -> vote_o=0xDEADBEEF, vote_valid_o=1, fault_o=0, err_cnt_o=0.
2. in2 bit 0 flipped for one sample, then clean -> vote_o correct, fault_o=1 once, err_cnt_o=1, state_o stays 00; the replica 2 counter returns to 0.
3. in3=0 for 3 valid samples with valid_i gaps between them, PERSIST_THR=3, others 0x5A5A5A5A -> after the 3rd sample state_o=01, faulty_rep_o=3. Later in3 garbage gives fault_o=0 and vote_o=0x5A5A5A5A.
4. DEGRADED, in1=0x1 and in2=0x2 -> fault_o=1, vote_valid_o=0, vote_o=0x5A5A5A5A (held), then state_o=10, no_majority_o=1. clear_i -> state_o=00, faulty_rep_o=0, err_cnt_o=0.
5. NORMAL, in1=1, in2=2, in3=4 -> state_o=10 directly, faulty_rep_o=0. 20 faulty samples with CNT_WIDTH=4 (re-cleared, restarted) -> err_cnt_o saturates at 15.
6. Assert rst_n mid-DEGRADED -> all outputs 0 immediately. With OUT_REG=1, repeat case 1 -> vote_o appears one cycle after valid_i.

Source files
------------

// File: rtl/cv32e40p_tmr_vote_manager_if.sv
// Bus bundle between a triplicated block, the TMR vote manager and its consumer.
// master: drives replicas/valid/clear and reads votes; slave: the vote manager.
interface cv32e40p_tmr_vote_manager_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 4
);
    logic                 valid_i;
    logic [WIDTH-1:0]     in1_i;
    logic [WIDTH-1:0]     in2_i;
    logic [WIDTH-1:0]     in3_i;
    logic                 clear_i;
    logic [WIDTH-1:0]     vote_o;
    logic                 vote_valid_o;
    logic                 fault_o;
    logic                 no_majority_o;
    logic [1:0]           state_o;
    logic [1:0]           faulty_rep_o;
    logic [CNT_WIDTH-1:0] err_cnt_o;

    modport master (
        output valid_i, in1_i, in2_i, in3_i, clear_i,
        input  vote_o, vote_valid_o, fault_o, no_majority_o,
        input  state_o, faulty_rep_o, err_cnt_o
    );

    modport slave (
        input  valid_i, in1_i, in2_i, in3_i, clear_i,
        output vote_o, vote_valid_o, fault_o, no_majority_o,
        output state_o, faulty_rep_o, err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_tmr_vote_manager.sv
// TMR voter with persistent-fault isolation: NORMAL -> DEGRADED (duplex) -> FAILED.
// Ports: clk, rst_n (async low), bus (slave: replicas/valid/clear in, vote/status out).
module cv32e40p_tmr_vote_manager #(
    parameter int WIDTH       = 32,
    parameter int PERSIST_THR = 3,
    parameter int CNT_WIDTH   = 4,
    parameter int OUT_REG     = 0
) (
    input logic clk,
    input logic rst_n,
    cv32e40p_tmr_vote_manager_if.slave bus
);
    localparam int RW = $clog2(PERSIST_THR + 1);
    localparam logic [RW-1:0] THR_R = RW'(PERSIST_THR);

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        DEGRADED = 2'b01,
        FAILED   = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           rep_q, rep_d;
    logic [2:0][RW-1:0]   run_q, run_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0]     held_q;

    logic [2:0][WIDTH-1:0] w;
    logic [WIDTH-1:0]      maj, pa, pb, vote;
    logic [2:0]            dis, qual;
    logic                  all_diff, vv, flt;

    assign w[0] = bus.in1_i;
    assign w[1] = bus.in2_i;
    assign w[2] = bus.in3_i;

    assign maj      = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    assign dis[0]   = w[0] != maj;
    assign dis[1]   = w[1] != maj;
    assign dis[2]   = w[2] != maj;
    assign all_diff = (w[0] != w[1]) && (w[0] != w[2]) && (w[1] != w[2]);

    // Surviving pair once a replica has been isolated
    always_comb begin
        pa = w[0];
        pb = w[1];
        case (rep_q)
            2'd1:    begin pa = w[1]; pb = w[2]; end
            2'd2:    begin pa = w[0]; pb = w[2]; end
            default: begin pa = w[0]; pb = w[1]; end
        endcase
    end

    always_comb begin
        vote    = held_q;
        vv      = 1'b0;
        flt     = 1'b0;
        qual    = '0;
        state_d = state_q;
        rep_d   = rep_q;
        run_d   = run_q;
        err_d   = err_q;
        case (state_q)
            NORMAL: begin
                vote = maj;
                vv   = bus.valid_i & ~all_diff;
                flt  = bus.valid_i & (|dis);
                if (bus.valid_i) begin
                    for (int i = 0; i < 3; i++) begin
                        if (dis[i])
                            run_d[i] = (run_q[i] == THR_R) ? run_q[i]
                                                           : run_q[i] + RW'(1);
                        else
                            run_d[i] = '0;
                        qual[i] = (run_d[i] == THR_R);
                    end
                    // No majority, or several persistent offenders: give up
                    if (all_diff || $countones(qual) > 1) begin
                        state_d = FAILED;
                    end else if (qual != 3'b000) begin
                        state_d = DEGRADED;
                        unique case (1'b1)
                            qual[0]: rep_d = 2'd1;
                            qual[1]: rep_d = 2'd2;
                            qual[2]: rep_d = 2'd3;
                            default: rep_d = rep_q;
                        endcase
                    end
                end
            end
            DEGRADED: begin
                if (pa == pb) begin
                    vote = pa;
                    vv   = bus.valid_i;
                end else begin
                    flt = bus.valid_i;
                    if (bus.valid_i) state_d = FAILED;
                end
            end
            default: ;
        endcase
        if (flt && err_q != {CNT_WIDTH{1'b1}}) err_d = err_q + CNT_WIDTH'(1);
        // The sample is still voted, but all bookkeeping restarts
        if (bus.clear_i) begin
            state_d = NORMAL;
            rep_d   = 2'd0;
            run_d   = '0;
            err_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            rep_q   <= 2'd0;
            run_q   <= '0;
            err_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            run_q   <= run_d;
            err_q   <= err_d;
            if (vv) held_q <= vote;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.faulty_rep_o  = rep_q;
    assign bus.err_cnt_o     = err_q;
    assign bus.no_majority_o = (state_q == FAILED);

    if (OUT_REG != 0) begin : g_reg
        logic [WIDTH-1:0] vote_r;
        logic             vv_r, flt_r;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vote_r <= '0;
                vv_r   <= 1'b0;
                flt_r  <= 1'b0;
            end else begin
                vote_r <= vote;
                vv_r   <= vv;
                flt_r  <= flt;
            end
        end
        assign bus.vote_o       = vote_r;
        assign bus.vote_valid_o = vv_r;
        assign bus.fault_o      = flt_r;
    end else begin : g_comb
        // Outputs read zero while reset is held, even with live inputs
        assign bus.vote_o       = rst_n ? vote : '0;
        assign bus.vote_valid_o = rst_n & vv;
        assign bus.fault_o      = rst_n & flt;
    end
endmodule

// File: tb/tb_cv32e40p_tmr_vote_manager.sv
// Randomised and directed bench for cv32e40p_tmr_vote_manager.
// Drives a combinational and a registered-output instance with identical stimulus.
module tb_cv32e40p_tmr_vote_manager;
    localparam int W   = 32;
    localparam int THR = 3;
    localparam int CW  = 4;
    localparam int EMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cv32e40p_tmr_vote_manager_if #(.WIDTH(W), .CNT_WIDTH(CW)) if0 ();
    cv32e40p_tmr_vote_manager_if #(.WIDTH(W), .CNT_WIDTH(CW)) if1 ();

    assign if1.valid_i = if0.valid_i;
    assign if1.in1_i   = if0.in1_i;
    assign if1.in2_i   = if0.in2_i;
    assign if1.in3_i   = if0.in3_i;
    assign if1.clear_i = if0.clear_i;

    cv32e40p_tmr_vote_manager #(.WIDTH(W), .PERSIST_THR(THR),
        .CNT_WIDTH(CW), .OUT_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    cv32e40p_tmr_vote_manager #(.WIDTH(W), .PERSIST_THR(THR),
        .CNT_WIDTH(CW), .OUT_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int tests = 0;
    int fails = 0;

    // Reference model: integer bookkeeping of the fault-management rules
    int          m_state;
    int          m_rep;
    int          m_run [3];
    int          m_err;
    logic [W-1:0] m_held;
    logic        s_v, s_clr, s_has_maj;
    logic [W-1:0] s_in [3];
    logic [W-1:0] e_vote;
    logic        e_vv, e_f;

    function automatic logic [W-1:0] bit_major(logic [W-1:0] a, logic [W-1:0] b,
                                               logic [W-1:0] c);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) begin
            int ones;
            ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
            r[k] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_rep   = 0;
        m_err   = 0;
        m_held  = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    task automatic model_comb();
        int nd;
        int o [2];
        int n;
        s_has_maj = (s_in[0] == s_in[1]) || (s_in[0] == s_in[2]) ||
                    (s_in[1] == s_in[2]);
        if (m_state == 0) begin
            e_vote = bit_major(s_in[0], s_in[1], s_in[2]);
            nd = 0;
            for (int i = 0; i < 3; i++) if (s_in[i] != e_vote) nd++;
            e_vv = s_v && s_has_maj;
            e_f  = s_v && (nd > 0);
        end else if (m_state == 1) begin
            n = 0;
            for (int i = 0; i < 3; i++) if (i + 1 != m_rep) begin o[n] = i; n++; end
            if (s_in[o[0]] == s_in[o[1]]) begin
                e_vote = s_in[o[0]]; e_vv = s_v; e_f = 1'b0;
            end else begin
                e_vote = m_held; e_vv = 1'b0; e_f = s_v;
            end
        end else begin
            e_vote = m_held; e_vv = 1'b0; e_f = 1'b0;
        end
    endtask

    task automatic model_seq();
        int nq, qi;
        if (s_v && e_vv) m_held = e_vote;
        if (s_clr) begin
            m_state = 0; m_rep = 0; m_err = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            return;
        end
        if (e_f) m_err = (m_err < EMAX) ? m_err + 1 : EMAX;
        if (m_state == 0 && s_v) begin
            nq = 0; qi = 0;
            for (int i = 0; i < 3; i++) begin
                m_run[i] = (s_in[i] != e_vote) ? ((m_run[i] < THR) ? m_run[i] + 1 : THR) : 0;
                if (m_run[i] == THR) begin nq++; qi = i; end
            end
            if (!s_has_maj || nq > 1) m_state = 2;
            else if (nq == 1) begin m_state = 1; m_rep = qi + 1; end
        end else if (m_state == 1 && s_v && e_f) begin
            m_state = 2;
        end
    endtask

    task automatic apply(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic clr);
        @(negedge clk);
        if0.valid_i = v; if0.in1_i = a; if0.in2_i = b; if0.in3_i = c;
        if0.clear_i = clr;
        s_v = v; s_clr = clr; s_in[0] = a; s_in[1] = b; s_in[2] = c;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_seq();
    endtask

    task automatic test_reset();
        if0.valid_i = 1'b0; if0.clear_i = 1'b0;
        if0.in1_i = '0; if0.in2_i = '0; if0.in3_i = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        tests++;
        if (if0.state_o !== 2'b00 || if0.faulty_rep_o !== 2'b00 ||
            if0.err_cnt_o !== '0 || if0.no_majority_o !== 1'b0 ||
            if0.vote_o !== '0 || if0.vote_valid_o !== 1'b0 || if0.fault_o !== 1'b0) begin
            fails++;
            $display("FAIL reset: state=%b rep=%0d err=%0d nm=%b vote=%h vv=%b f=%b, required all 0",
                if0.state_o, if0.faulty_rep_o, if0.err_cnt_o, if0.no_majority_o,
                if0.vote_o, if0.vote_valid_o, if0.fault_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        apply(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        tests++;
        if (if0.vote_o !== 32'hDEADBEEF || if0.vote_valid_o !== 1'b1 || if0.fault_o !== 1'b0) begin
            fails++;
            $display("FAIL normal_vote: vote=%h vv=%b f=%b, required DEADBEEF 1 0",
                if0.vote_o, if0.vote_valid_o, if0.fault_o);
        end
        tick();
        tests++;
        if (if0.err_cnt_o !== 4'd0 || if0.state_o !== 2'b00) begin
            fails++;
            $display("FAIL normal_status: err=%0d state=%b, required 0 00",
                if0.err_cnt_o, if0.state_o);
        end
    endtask

    task automatic test_single_flip();
        logic [W-1:0] g;
        g = 32'hDEADBEEF;
        apply(1'b1, g, g ^ 32'h1, g, 1'b0);
        tests++;
        if (if0.vote_o !== g || if0.fault_o !== 1'b1 || if0.vote_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL flip_vote: vote=%h f=%b vv=%b, required %h 1 1",
                if0.vote_o, if0.fault_o, if0.vote_valid_o, g);
        end
        tick();
        tests++;
        if (if0.err_cnt_o !== 4'd1 || if0.state_o !== 2'b00) begin
            fails++;
            $display("FAIL flip_err: err=%0d state=%b, required 1 00",
                if0.err_cnt_o, if0.state_o);
        end
        apply(1'b1, g, g, g, 1'b0);
        tests++;
        if (if0.fault_o !== 1'b0) begin
            fails++;
            $display("FAIL flip_clean: f=%b, required 0", if0.fault_o);
        end
        tick();
        // Two more isolated flips: a non-reset run counter would isolate replica 2
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, g, g ^ 32'h1, g, 1'b0); tick();
            apply(1'b1, g, g, g, 1'b0); tick();
        end
        tests++;
        if (if0.state_o !== 2'b00 || if0.err_cnt_o !== 4'd3) begin
            fails++;
            $display("FAIL flip_run_reset: state=%b err=%0d, required 00 3",
                if0.state_o, if0.err_cnt_o);
        end
    endtask

    task automatic test_degrade();
        logic [W-1:0] g;
        g = 32'h5A5A5A5A;
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, g, g, 32'h0, 1'b0); tick();
            if (k < 2) begin
                apply(1'b0, g, g, 32'h0, 1'b0); tick();
            end
        end
        tests++;
        if (if0.state_o !== 2'b01 || if0.faulty_rep_o !== 2'd3) begin
            fails++;
            $display("FAIL degrade_enter: state=%b rep=%0d, required 01 3",
                if0.state_o, if0.faulty_rep_o);
        end
        apply(1'b1, g, g, 32'hF00DCAFE, 1'b0);
        tests++;
        if (if0.fault_o !== 1'b0 || if0.vote_o !== g || if0.vote_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL degrade_ignore: f=%b vote=%h vv=%b, required 0 %h 1",
                if0.fault_o, if0.vote_o, if0.vote_valid_o, g);
        end
        tick();
    endtask

    task automatic test_duplex_fail();
        apply(1'b1, 32'h1, 32'h2, 32'h0, 1'b0);
        tests++;
        if (if0.fault_o !== 1'b1 || if0.vote_valid_o !== 1'b0 || if0.vote_o !== 32'h5A5A5A5A) begin
            fails++;
            $display("FAIL duplex_mismatch: f=%b vv=%b vote=%h, required 1 0 5a5a5a5a",
                if0.fault_o, if0.vote_valid_o, if0.vote_o);
        end
        tick();
        tests++;
        if (if0.state_o !== 2'b10 || if0.no_majority_o !== 1'b1) begin
            fails++;
            $display("FAIL duplex_failed: state=%b nm=%b, required 10 1",
                if0.state_o, if0.no_majority_o);
        end
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b1); tick();
        tests++;
        if (if0.state_o !== 2'b00 || if0.faulty_rep_o !== 2'd0 ||
            if0.err_cnt_o !== 4'd0 || if0.no_majority_o !== 1'b0) begin
            fails++;
            $display("FAIL clear: state=%b rep=%0d err=%0d nm=%b, required 00 0 0 0",
                if0.state_o, if0.faulty_rep_o, if0.err_cnt_o, if0.no_majority_o);
        end
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();
    endtask

    task automatic test_all_differ();
        logic [W-1:0] g;
        apply(1'b1, 32'h1, 32'h2, 32'h4, 1'b0);
        tests++;
        if (if0.vote_valid_o !== 1'b0 || if0.fault_o !== 1'b1) begin
            fails++;
            $display("FAIL nomaj_sample: vv=%b f=%b, required 0 1",
                if0.vote_valid_o, if0.fault_o);
        end
        tick();
        tests++;
        if (if0.state_o !== 2'b10 || if0.faulty_rep_o !== 2'd0) begin
            fails++;
            $display("FAIL nomaj_state: state=%b rep=%0d, required 10 0",
                if0.state_o, if0.faulty_rep_o);
        end
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b1); tick();
        // Rotate the corrupted replica so no run builds: 20 faults, no isolation
        g = 32'h13572468;
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] x [3];
            for (int i = 0; i < 3; i++) x[i] = g;
            x[k % 3] = g ^ 32'h80;
            apply(1'b1, x[0], x[1], x[2], 1'b0); tick();
        end
        tests++;
        if (if0.err_cnt_o !== 4'd15 || if0.state_o !== 2'b00) begin
            fails++;
            $display("FAIL err_saturate: err=%0d state=%b, required 15 00",
                if0.err_cnt_o, if0.state_o);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] pv;
        logic         pvv, pf;
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b1); tick();
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] base;
            logic [W-1:0] x [3];
            logic v, clr;
            base = $urandom;
            for (int i = 0; i < 3; i++) begin
                x[i] = base;
                if ($urandom_range(5) == 0) x[i] = base ^ (32'h1 << $urandom_range(31));
                if ($urandom_range(39) == 0) x[i] = $urandom;
            end
            v   = ($urandom_range(3) != 0);
            clr = ($urandom_range(24) == 0);
            apply(v, x[0], x[1], x[2], clr);
            tests++;
            if (if0.vote_o !== e_vote || if0.vote_valid_o !== e_vv || if0.fault_o !== e_f) begin
                fails++;
                $display("FAIL rand_vote[%0d]: vote=%h vv=%b f=%b, required %h %b %b",
                    n, if0.vote_o, if0.vote_valid_o, if0.fault_o, e_vote, e_vv, e_f);
            end
            pv = e_vote; pvv = e_vv; pf = e_f;
            tick();
            tests++;
            if (int'(if0.state_o) != m_state || int'(if0.faulty_rep_o) != m_rep ||
                int'(if0.err_cnt_o) != m_err || if0.no_majority_o !== (m_state == 2)) begin
                fails++;
                $display("FAIL rand_status[%0d]: state=%0d rep=%0d err=%0d nm=%b, required %0d %0d %0d",
                    n, if0.state_o, if0.faulty_rep_o, if0.err_cnt_o, if0.no_majority_o,
                    m_state, m_rep, m_err);
            end
            tests++;
            if (if1.vote_o !== pv || if1.vote_valid_o !== pvv || if1.fault_o !== pf) begin
                fails++;
                $display("FAIL rand_outreg[%0d]: vote=%h vv=%b f=%b, required %h %b %b",
                    n, if1.vote_o, if1.vote_valid_o, if1.fault_o, pv, pvv, pf);
            end
        end
    endtask

    task automatic test_reset_degraded();
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b1); tick();
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 32'h77, 32'h0, 32'h77, 1'b0); tick();
        end
        tests++;
        if (if0.state_o !== 2'b01 || if0.faulty_rep_o !== 2'd2) begin
            fails++;
            $display("FAIL rst_pre: state=%b rep=%0d, required 01 2",
                if0.state_o, if0.faulty_rep_o);
        end
        @(negedge clk);
        if0.valid_i = 1'b1;
        if0.in1_i = 32'h77; if0.in2_i = 32'h77; if0.in3_i = 32'h77;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (if0.state_o !== 2'b00 || if0.faulty_rep_o !== 2'd0 || if0.err_cnt_o !== '0 ||
            if0.no_majority_o !== 1'b0 || if0.vote_o !== '0 || if0.vote_valid_o !== 1'b0 ||
            if0.fault_o !== 1'b0 || if1.vote_o !== '0 || if1.vote_valid_o !== 1'b0 ||
            if1.state_o !== 2'b00) begin
            fails++;
            $display("FAIL rst_async: state=%b rep=%0d err=%0d nm=%b vote=%h vv=%b f=%b vote1=%h, required all 0",
                if0.state_o, if0.faulty_rep_o, if0.err_cnt_o, if0.no_majority_o,
                if0.vote_o, if0.vote_valid_o, if0.fault_o, if1.vote_o);
        end
        model_reset();
        if0.valid_i = 1'b0; if0.clear_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_out_reg();
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); tick();
        apply(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        tests++;
        if (if1.vote_valid_o !== 1'b0 || if0.vote_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL outreg_early: vv1=%b vv0=%b, required 0 1",
                if1.vote_valid_o, if0.vote_valid_o);
        end
        tick();
        tests++;
        if (if1.vote_o !== 32'hDEADBEEF || if1.vote_valid_o !== 1'b1 || if1.fault_o !== 1'b0) begin
            fails++;
            $display("FAIL outreg_late: vote=%h vv=%b f=%b, required DEADBEEF 1 0",
                if1.vote_o, if1.vote_valid_o, if1.fault_o);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_single_flip();
        test_degrade();
        test_duplex_fail();
        test_all_differ();
        test_random();
        test_reset_degraded();
        test_out_reg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
